// File: rtl/sound_pkg.sv
// Shared register map and address decode for the tone channel bank.
package sound_pkg;

  localparam int CH_BITS = 4;

  typedef enum logic {
    REG_PERIOD   = 1'b0,
    REG_DURATION = 1'b1
  } reg_sel_e;

  typedef struct packed {
    logic [CH_BITS-1:0] ch;
    reg_sel_e           sel;
  } reg_addr_t;

  // Bit 0 picks the register, the bits above it pick the channel.
  function automatic reg_addr_t decode_addr(input logic [CH_BITS:0] addr);
    reg_addr_t d;
    d.ch  = addr[CH_BITS:1];
    d.sel = reg_sel_e'(addr[0]);
    return d;
  endfunction

endpackage

// File: rtl/sound_channel_bank_if.sv
// CPU memory-mapped write/readback port of the tone channel bank.
interface sound_channel_bank_if #(
  parameter int NCH   = 4,
  parameter int DBITS = 32
) ();

  logic                  wr;
  logic [$clog2(NCH):0]  addr;
  logic [DBITS-1:0]      cpu_writedata;
  logic [DBITS-1:0]      cpu_readdata;

  modport master (output wr, output addr, output cpu_writedata, input cpu_readdata);
  modport slave  (input wr, input addr, input cpu_writedata, output cpu_readdata);

endinterface

// File: rtl/sound_channel.sv
// One tone channel: period/duration registers, square-wave generator and
// note countdown driven by the shared duration tick.
module sound_channel #(
  parameter int PBITS   = 24,
  parameter int DURBITS = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_period,
  input  logic               wr_duration,
  input  logic [PBITS-1:0]   period_data,
  input  logic [DURBITS-1:0] duration_data,
  input  logic               tick,
  output logic [PBITS-1:0]   period,
  output logic [DURBITS-1:0] remaining,
  output logic               tone,
  output logic               done,
  output logic               busy
);

  logic [PBITS-1:0] phase;
  logic             timed;
  logic             countdown;
  logic             expire;

  // A CPU write to this channel swallows the tick for this edge.
  assign countdown = tick && timed && !wr_period && !wr_duration;
  assign expire    = countdown && (remaining == DURBITS'(1));
  assign busy      = (period != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and later lines may safely override
  // earlier ones (done defaults low, then pulses on expiry).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period    <= '0;
      remaining <= '0;
      timed     <= 1'b0;
      phase     <= '0;
      tone      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (wr_period) begin
        period <= period_data;
        phase  <= '0;
        tone   <= 1'b0;
      end else if (expire) begin
        period <= '0;
        phase  <= '0;
        tone   <= 1'b0;
        done   <= 1'b1;
      end else if (period == '0) begin
        phase <= '0;
        tone  <= 1'b0;
      end else if (phase == period - PBITS'(1)) begin
        phase <= '0;
        tone  <= ~tone;
      end else begin
        phase <= phase + PBITS'(1);
      end

      if (wr_duration) begin
        remaining <= duration_data;
        timed     <= (duration_data != '0);
      end else if (countdown) begin
        remaining <= remaining - DURBITS'(1);
        if (expire) timed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sound_channel_bank.sv
// Bank of NCH tone channels on the CPU write path, with a shared duration
// prescaler, register readback and a popcount mix of the tone outputs.
module sound_channel_bank
  import sound_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DBITS    = 32,
  parameter int PBITS    = 24,
  parameter int DURBITS  = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  sound_channel_bank_if.slave        bus,
  output logic [NCH-1:0]             tone,
  output logic [NCH-1:0]             busy,
  output logic [NCH-1:0]             done,
  output logic [$clog2(NCH+1)-1:0]   mix_out
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int MW = $clog2(NCH+1);

  logic [CW-1:0]      presc;
  logic               tick;
  reg_addr_t          dec;
  logic [PBITS-1:0]   period_q    [NCH];
  logic [DURBITS-1:0] remaining_q [NCH];
  logic               unused_wdata;

  assign tick = (presc == CW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + CW'(1);
  end

  // Channel indices at or above NCH match no instance, so those writes drop.
  assign dec          = decode_addr((CH_BITS+1)'(bus.addr));
  assign unused_wdata = ^bus.cpu_writedata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = bus.wr && (dec.ch == CH_BITS'(i));

    sound_channel #(
      .PBITS   (PBITS),
      .DURBITS (DURBITS)
    ) u_ch (
      .clock         (clock),
      .reset_n       (reset_n),
      .wr_period     (hit && (dec.sel == REG_PERIOD)),
      .wr_duration   (hit && (dec.sel == REG_DURATION)),
      .period_data   (bus.cpu_writedata[PBITS-1:0]),
      .duration_data (bus.cpu_writedata[DURBITS-1:0]),
      .tick          (tick),
      .period        (period_q[i]),
      .remaining     (remaining_q[i]),
      .tone          (tone[i]),
      .done          (done[i]),
      .busy          (busy[i])
    );
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves it unassigned would infer a latch.
  always_comb begin
    bus.cpu_readdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (dec.ch == CH_BITS'(i)) begin
        bus.cpu_readdata = (dec.sel == REG_PERIOD) ? DBITS'(period_q[i])
                                                   : DBITS'(remaining_q[i]);
      end
    end
  end

  always_comb begin
    mix_out = '0;
    for (int i = 0; i < NCH; i++) mix_out = mix_out + MW'(tone[i]);
  end

endmodule

// File: tb/tb_sound_channel_bank.sv
// Directed test of sound_channel_bank with TICK_DIV=10: a 4-channel bank and
// a 3-channel bank for out-of-range addressing.
module tb_sound_channel_bank;
  import sound_pkg::*;

  logic clock;
  logic reset_n;
  logic [3:0] tone_a, busy_a, done_a;
  logic [2:0] mix_a;
  logic [2:0] tone_b, busy_b, done_b;
  logic [1:0] mix_b;

  int vectors;
  int miscompares;
  int ec;
  logic [31:0] exp_v;
  logic [3:0]  tone_or, busy_or, done_or;

  sound_channel_bank_if #(.NCH(4), .DBITS(32)) bus_a ();
  sound_channel_bank_if #(.NCH(3), .DBITS(32)) bus_b ();

  sound_channel_bank #(
    .NCH(4), .DBITS(32), .PBITS(24), .DURBITS(16), .TICK_DIV(10)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave),
    .tone(tone_a), .busy(busy_a), .done(done_a), .mix_out(mix_a)
  );

  sound_channel_bank #(
    .NCH(3), .DBITS(32), .PBITS(24), .DURBITS(16), .TICK_DIV(10)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave),
    .tone(tone_b), .busy(busy_b), .done(done_b), .mix_out(mix_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ec counts clock edges since reset release; DUT state after step() reflects edge ec.
  task automatic step();
    @(posedge clock);
    #1;
    ec++;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    bus_a.wr = 1'b1; bus_a.addr = a; bus_a.cpu_writedata = d;
    step();
    bus_a.wr = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    bus_b.wr = 1'b1; bus_b.addr = a; bus_b.cpu_writedata = d;
    step();
    bus_b.wr = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a, input string tag, input logic [31:0] exp);
    bus_a.addr = a;
    #1;
    check(tag, bus_a.cpu_readdata, exp);
  endtask

  task automatic rd_b(input logic [2:0] a, input string tag, input logic [31:0] exp);
    bus_b.addr = a;
    #1;
    check(tag, bus_b.cpu_readdata, exp);
  endtask

  initial begin
    vectors = 0; miscompares = 0; ec = 0;
    clock = 1'b0; reset_n = 1'b0;
    bus_a.wr = 1'b0; bus_a.addr = '0; bus_a.cpu_writedata = '0;
    bus_b.wr = 1'b0; bus_b.addr = '0; bus_b.cpu_writedata = '0;

    // Reset state
    repeat (3) step();
    check("rst_tone", tone_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_mix", mix_a, 0);
    rd_a(3'd1, "rst_rd", 0);
    reset_n = 1'b1; ec = 0;

    // Continuous tone on channel 1, period 3 (write edge 1)
    wr_a(3'd2, 32'd3);
    wr_a(3'd3, 32'd0);
    rd_a(3'd2, "c1_period_rd", 32'd3);
    rd_a(3'd3, "c1_rem_rd", 32'd0);
    check("c1_busy", busy_a, 4'b0010);
    while (ec <= 14) begin
      exp_v = ((ec - 1) / 3) % 2;
      check("c1_tone", tone_a[1], exp_v);
      check("c1_mix", mix_a, exp_v);
      step();
    end

    // Reset asserted after writes clears everything immediately
    reset_n = 1'b0;
    #1;
    check("rst2_tone", tone_a, 0);
    check("rst2_busy", busy_a, 0);
    check("rst2_mix", mix_a, 0);
    rd_a(3'd2, "rst2_period_rd", 0);
    step(); step();
    reset_n = 1'b1; ec = 0;
    tone_or = '0; busy_or = '0;
    repeat (1000) begin
      step();
      tone_or |= tone_a;
      busy_or |= busy_a;
    end
    check("idle_tone", tone_or, 0);
    check("idle_busy", busy_or, 0);

    // Timed note: ch0 period 2, duration 3; ticks act at edges 1010/1020/1030
    wr_a(3'd0, 32'd2);
    wr_a(3'd1, 32'd3);
    rd_a(3'd1, "t_rem3", 32'd3);
    step();
    check("t_tone_1003", tone_a[0], 1);
    while (ec < 1010) step();
    rd_a(3'd1, "t_rem2", 32'd2);
    while (ec < 1020) step();
    rd_a(3'd1, "t_rem1", 32'd1);
    while (ec < 1029) step();
    check("t_done_pre", done_a, 0);
    check("t_busy_pre", busy_a, 4'b0001);
    step();
    rd_a(3'd0, "t_period_exp", 0);
    check("t_tone_exp", tone_a[0], 0);
    check("t_done_exp", done_a, 4'b0001);
    check("t_busy_exp", busy_a, 0);
    step();
    check("t_done_post", done_a, 0);
    rd_a(3'd1, "t_rem0", 0);

    // Priority: period write on the expiring tick edge (1040)
    wr_a(3'd1, 32'd1);
    while (ec < 1039) step();
    wr_a(3'd0, 32'd5);
    rd_a(3'd0, "p_period5", 32'd5);
    rd_a(3'd1, "p_rem_kept", 32'd1);
    check("p_no_done", done_a, 0);
    check("p_busy", busy_a, 4'b0001);
    step();
    check("p_no_done_next", done_a, 0);
    while (ec < 1049) step();
    rd_a(3'd1, "p_rem_still1", 32'd1);
    step();
    check("p_done_1050", done_a, 4'b0001);
    check("p_tone_1050", tone_a, 0);
    rd_a(3'd0, "p_period0", 0);

    // Mix: all four channels period 1, written on same-parity edges
    wr_a(3'd0, 32'd1); step();
    wr_a(3'd2, 32'd1); step();
    wr_a(3'd4, 32'd1); step();
    wr_a(3'd6, 32'd1);
    step();
    check("m_tone_all", tone_a, 4'b1111);
    check("m_mix4a", mix_a, 3'd4);
    step();
    check("m_mix0a", mix_a, 3'd0);
    step();
    check("m_mix4b", mix_a, 3'd4);
    step();
    check("m_mix0b", mix_a, 3'd0);
    wr_a(3'd4, 32'd0);
    check("m_tone_3", tone_a, 4'b1011);
    check("m_mix3a", mix_a, 3'd3);
    check("m_busy_3", busy_a, 4'b1011);
    step();
    check("m_mix0c", mix_a, 3'd0);
    step();
    check("m_mix3b", mix_a, 3'd3);

    // Out-of-range channel on the 3-channel bank
    wr_b(3'd6, 32'd7);
    rd_b(3'd6, "oor_period_rd", 0);
    rd_b(3'd7, "oor_rem_rd", 0);
    check("oor_busy", busy_b, 0);
    check("oor_tone", tone_b, 0);
    wr_b(3'd4, 32'd9);
    rd_b(3'd4, "b_ch2_period", 32'd9);
    check("b_ch2_busy", busy_b, 3'b100);
    rd_b(3'd6, "oor_period_rd2", 0);

    // Reset mid-countdown: immediate silence, no done pulse afterwards
    wr_a(3'd7, 32'd2);
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    check("mr_tone", tone_a, 0);
    check("mr_busy", busy_a, 0);
    check("mr_done", done_a, 0);
    check("mr_mix", mix_a, 0);
    check("mr_busy_b", busy_b, 0);
    rd_a(3'd7, "mr_rem_rd", 0);
    rd_a(3'd6, "mr_period_rd", 0);
    step(); step();
    reset_n = 1'b1; ec = 0;
    done_or = '0;
    repeat (40) begin
      step();
      done_or |= done_a;
    end
    check("mr_no_done", done_or, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_channel_bank.md
Name: sound_channel_bank

Overview:
Multi-channel successor to the single period register. Holds a CPU-writable period and duration register per channel and generates a square-wave tone per channel from them. Timed notes silence themselves automatically. Sits on the CPU memory-mapped write path and feeds the audio output stage with per-channel tones and a mixed level.

Parameters:
NCH, 4, number of tone channels (1..16)
DBITS, 32, CPU data bus width
PBITS, 24, period register width (PBITS <= DBITS)
DURBITS, 16, duration register width (DURBITS <= DBITS)
TICK_DIV, 100000, clock cycles per duration tick (>= 2)

Ports:
clock  input  1  system clock, all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
wr  input  1  write enable, sampled at posedge clock
addr  input  $clog2(NCH)+1  bit0 selects register (0 = period, 1 = duration); upper bits select channel
cpu_writedata  input  DBITS  write data
cpu_readdata  output  DBITS  combinational readback of addressed register
tone  output  NCH  per-channel square wave
busy  output  NCH  channel sounding (period != 0)
done  output  NCH  one-cycle pulse when a timed note expires
mix_out  output  $clog2(NCH+1)  count of tone bits currently high

Behaviour:
- Reset (asynchronous, reset_n=0): every period, remaining, timed flag, phase counter, tone bit, done bit, and the tick prescaler go to 0. Outputs read 0 during and after reset until the first write.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick is high for one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
  - Shared by all channels.
- Period write (wr=1, bit0=0, channel < NCH):
  - period <= cpu_writedata[PBITS-1:0].
  - Phase counter <= 0 and tone <= 0 on the same edge.
  - The timed flag and remaining count are unaffected.
- Duration write (wr=1, bit0=1, channel < NCH):
  - remaining <= cpu_writedata[DURBITS-1:0].
  - timed <= (value != 0).
  - A value of 0 means continuous play: no countdown.
- Writes to channel index >= NCH are ignored. Reads of those indices return 0.
- Tone generation per channel:
  - If period == 0: phase counter held at 0, tone held at 0.
  - Otherwise the counter increments each cycle. When counter == period-1, the counter wraps to 0 and tone toggles.
  - Output period is therefore 2*period cycles at 50% duty. Period 1 toggles tone every cycle.
- Countdown, on tick for each channel with timed=1:
  - remaining decrements.
  - When decrementing from 1 to 0: period <= 0, timed <= 0, tone <= 0, phase counter <= 0, and done pulses high for exactly the following cycle.
  - timed=1 with period=0 still counts down and still pulses done at expiry.
- Simultaneous events on the same channel and edge:
  - Any CPU write to the channel takes priority over the tick for that channel. That tick's decrement is skipped for that channel only.
  - A period write on the expiry edge wins: the new period is kept, and there is no expiry and no done pulse.
- busy = (period != 0), combinational from registers.
- mix_out = popcount(tone), combinational, zero-extended.
- cpu_readdata:
  - bit0=0: period, zero-extended.
  - bit0=1: remaining, zero-extended.
- Latency:
  - A write is visible on cpu_readdata and busy one cycle after the write edge.
  - The first tone toggle occurs period cycles after the write edge.
- reset_n asserted mid-note: immediate silence. All state is cleared with no done pulse.

Decomposition:
- Package sound_pkg holds:
  - REG_PERIOD=0 and REG_DURATION=1 offset constants.
  - Helper function for address decode (channel index, register select).
- Sub-module sound_channel, instantiated NCH times via generate. It holds period, remaining, timed, phase counter, tone, and done, and takes write-strobe, select, data, and tick inputs.
- The top level owns the prescaler, address decode, readback mux, and popcount.

Test Plan:
- Reset: hold reset_n=0 after writes -> all outputs 0; tone stays 0 with no writes for 1000 cycles.
- Continuous tone: write period=3 to channel 1 with duration=0 -> tone[1] toggles every 3 cycles (period 6), busy=4'b0010, readback of channel 1 period returns 3.
- Timed note, TICK_DIV=10: channel 0 period=2, duration=3 -> tone runs, remaining reads 3,2,1 across ticks; on the third tick period reads 0, tone[0]=0, done[0] pulses exactly 1 cycle, busy[0]=0.
- Priority: issue a period=5 write on the same edge as the expiring tick (remaining=1) -> period reads 5, no done pulse, remaining stays 1 for one more tick.
- Mix: channels 0..3 all period=1 with aligned writes -> mix_out alternates 4 and 0. Set channel 2 period=0 -> mix_out alternates 3 and 0.
- Out-of-range and mid-operation: with NCH=3, write to channel 3 -> no state change, readback 0. Assert reset_n mid-countdown -> immediate silence, no done pulse.
